// File: rtl/pipeline_ctrl_pkg.sv
// Shared types for the pipeline stall/flush sequencer.
//   pipe_ctrl_state_t : multi-cycle op FSM states
//   stall_cause_t     : which source won the priority arbitration this cycle (debug/trace)
package pipeline_ctrl_pkg;

    typedef enum logic {
        RUN     = 1'b0,
        MC_BUSY = 1'b1
    } pipe_ctrl_state_t;

    typedef enum logic [2:0] {
        NONE         = 3'd0,
        DM_WAIT      = 3'd1,
        MC_EXEC      = 3'd2,
        BRANCH_FLUSH = 3'd3,
        LOAD_USE     = 3'd4
    } stall_cause_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-low clear.
// Ports:
//   clk_i   : clock
//   clr_ni  : synchronous clear, active low (dominates enable)
//   en_i    : count enable, adds one per cycle until all-ones
//   count_o : current count
module sat_counter #(
    parameter int unsigned Width = 32
) (
    input  logic             clk_i,
    input  logic             clr_ni,
    input  logic             en_i,
    output logic [Width-1:0] count_o
);

    logic [Width-1:0] count_q;
    logic [Width-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (en_i && (count_q != {Width{1'b1}})) begin
            count_d = count_q + Width'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!clr_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/pipeline_stall_controller.sv
// Central sequencer for the 5-stage pipeline: merges data-memory wait, multi-cycle execute ops,
// branch redirect and load-use hazards into per-stage flop enables and NOP-flush controls.
// Ports:
//   clk, rst (sync, active low)       : clock / reset
//   load_use_stall_req                : decode instr depends on a load in execute
//   mc_start, mc_latency              : decode instr is a multi-cycle op needing mc_latency cycles
//   mc_done_early                     : multi-cycle unit finished before the full latency
//   branch_taken                      : execute-stage redirect
//   dm_busy                           : data memory not ready
//   pc_enable, *_enable_ff            : per-stage flop load enables
//   f_to_d_flush/d_to_e_flush/e_to_m_flush : load NOP into the given pipeline flop
//   mc_busy                           : multi-cycle op occupying execute
//   stall_cycle_count                 : saturating count of cycles with pc_enable low
module pipeline_stall_controller
    import pipeline_ctrl_pkg::*;
#(
    parameter int unsigned XLEN         = 32,
    parameter int unsigned MC_CNT_WIDTH = 6
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load_use_stall_req,
    input  logic                    mc_start,
    input  logic [MC_CNT_WIDTH-1:0] mc_latency,
    input  logic                    mc_done_early,
    input  logic                    branch_taken,
    input  logic                    dm_busy,
    output logic                    pc_enable,
    output logic                    f_to_d_enable_ff,
    output logic                    d_to_e_enable_ff,
    output logic                    e_to_m_enable_ff,
    output logic                    m_to_w_enable_ff,
    output logic                    f_to_d_flush,
    output logic                    d_to_e_flush,
    output logic                    e_to_m_flush,
    output logic                    mc_busy,
    output logic [XLEN-1:0]         stall_cycle_count
);

    pipe_ctrl_state_t        state_q, state_d;
    logic [MC_CNT_WIDTH-1:0] mc_cnt_q, mc_cnt_d;
    stall_cause_t            stall_cause;
    logic                    mc_last;

    // Final execute cycle of the op: either the latency ran out or the unit finished early.
    assign mc_last = (mc_cnt_q == MC_CNT_WIDTH'(1)) || mc_done_early;

    always_comb begin
        state_d          = state_q;
        mc_cnt_d         = mc_cnt_q;
        pc_enable        = 1'b1;
        f_to_d_enable_ff = 1'b1;
        d_to_e_enable_ff = 1'b1;
        e_to_m_enable_ff = 1'b1;
        m_to_w_enable_ff = 1'b1;
        f_to_d_flush     = 1'b0;
        d_to_e_flush     = 1'b0;
        e_to_m_flush     = 1'b0;

        // Priority arbitration: first matching source owns the pipeline this cycle.
        if (dm_busy) begin
            stall_cause = DM_WAIT;
        end else if (state_q == MC_BUSY) begin
            stall_cause = MC_EXEC;
        end else if (branch_taken) begin
            stall_cause = BRANCH_FLUSH;
        end else if (load_use_stall_req) begin
            stall_cause = LOAD_USE;
        end else begin
            stall_cause = NONE;
        end

        unique case (stall_cause)
            DM_WAIT: begin
                // Freeze everything, including the FSM and latency counter.
                pc_enable        = 1'b0;
                f_to_d_enable_ff = 1'b0;
                d_to_e_enable_ff = 1'b0;
                e_to_m_enable_ff = 1'b0;
                m_to_w_enable_ff = 1'b0;
            end
            MC_EXEC: begin
                // Front stages hold even on the release cycle; they resume next cycle.
                pc_enable        = 1'b0;
                f_to_d_enable_ff = 1'b0;
                d_to_e_enable_ff = 1'b0;
                if (mc_last) begin
                    state_d  = RUN;
                    mc_cnt_d = '0;
                end else begin
                    e_to_m_flush = 1'b1;
                    mc_cnt_d     = mc_cnt_q - MC_CNT_WIDTH'(1);
                end
            end
            BRANCH_FLUSH: begin
                f_to_d_flush = 1'b1;
                d_to_e_flush = 1'b1;
            end
            LOAD_USE: begin
                pc_enable        = 1'b0;
                f_to_d_enable_ff = 1'b0;
                d_to_e_flush     = 1'b1;
            end
            NONE: begin
                // Latency 0 or 1 is an ordinary single-cycle op.
                if (mc_start && (mc_latency >= MC_CNT_WIDTH'(2))) begin
                    state_d  = MC_BUSY;
                    mc_cnt_d = mc_latency;
                end
            end
            default: ;
        endcase

        // Reset forces a flushing, free-running pipeline regardless of the sources.
        if (!rst) begin
            pc_enable        = 1'b1;
            f_to_d_enable_ff = 1'b1;
            d_to_e_enable_ff = 1'b1;
            e_to_m_enable_ff = 1'b1;
            m_to_w_enable_ff = 1'b1;
            f_to_d_flush     = 1'b1;
            d_to_e_flush     = 1'b1;
            e_to_m_flush     = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= RUN;
            mc_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            mc_cnt_q <= mc_cnt_d;
        end
    end

    assign mc_busy = rst && (state_q == MC_BUSY);

    sat_counter #(
        .Width(XLEN)
    ) u_stall_cnt (
        .clk_i  (clk),
        .clr_ni (rst),
        .en_i   (~pc_enable),
        .count_o(stall_cycle_count)
    );

endmodule
